// File: rtl/encoder42_hs_pkg.sv
// Shared definitions for the edge-capturing priority encoder:
// default sizes, a ceiling-log2 helper and the FSM state codes.
package encoder42_hs_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int N_DEF = 4;
    localparam int W_DEF = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/encoder42_hs_if.sv
// Event-code delivery bus.
// Handshake: a code transfers on a rising clk edge where valid and ready are
// both 1; while valid=1 and ready=0, y holds stable. ovf is a one-cycle pulse.
interface encoder42_hs_if #(
    parameter int W = 2
);
    logic         valid;
    logic [W-1:0] y;
    logic         ovf;
    logic         ready;

    modport master (output valid, output y, output ovf, input ready);
    modport slave  (input valid, input y, input ovf, output ready);
endinterface

// File: rtl/encoder42_hs_prio_enc_lsb.sv
// Combinational encoder returning the index of the lowest set bit of in_i.
module prio_enc_lsb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] in_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder42_hs.sv
// Captures rising edges on request lines into a pending set and delivers the
// lowest pending index, one code per handshake.
module encoder42_hs
    import encoder42_hs_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    encoder42_hs_if.master       bus,
    output logic [0:0]           dbg_state_o,
    output logic [N-1:0]         dbg_pending_o
);

    logic [N-1:0] req_q_q, req_q_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] y_q, y_d;
    logic         ovf_q, ovf_d;
    logic [0:0]   state_q, state_d;

    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] nxt;
    logic         acc;
    logic [W-1:0] idx_pend, idx_nxt;
    logic         any_pend, any_nxt;

    assign acc  = (state_q == ST_OFFER) && bus.ready;
    assign rise = req & ~req_q_q;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = acc && (y_q == W'(i));
        end
    end

    assign nxt       = pending_q & ~clr;
    assign req_q_d   = req;
    // A rise on a bit that is being cleared this cycle is a fresh event, not a loss.
    assign pending_d = nxt | rise;
    assign ovf_d     = |(rise & nxt);

    prio_enc_lsb #(.N(N), .W(W)) u_enc_pend (
        .in_i  (pending_q),
        .idx_o (idx_pend),
        .any_o (any_pend)
    );

    prio_enc_lsb #(.N(N), .W(W)) u_enc_nxt (
        .in_i  (nxt),
        .idx_o (idx_nxt),
        .any_o (any_nxt)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    y_d     = idx_pend;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Same-cycle rises are not in nxt; they surface via IDLE.
                if (bus.ready) begin
                    if (any_nxt) begin
                        y_d = idx_nxt;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_q   <= '1;
            pending_q <= '0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            req_q_q   <= req_q_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    assign bus.valid     = (state_q == ST_OFFER);
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state_o   = state_q;
    assign dbg_pending_o = pending_q;

endmodule

// File: tb/tb_encoder42_hs.sv
// Directed bench for encoder42_hs: expected codes queued at stimulus time,
// popped by a monitor on every accepted handshake.
module tb_encoder42_hs;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [0:0]   dbg_state;
    logic [N-1:0] dbg_pending;

    encoder42_hs_if #(.W(W)) bus ();

    encoder42_hs #(.N(N), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .bus           (bus),
        .dbg_state_o   (dbg_state),
        .dbg_pending_o (dbg_pending)
    );

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // monitor: a transfer happens at the next posedge when valid&ready now
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ovf) ovf_cnt++;
            if (bus.valid && bus.ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_code: got %0d expected none", bus.y);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.y !== e) begin
                        failures++;
                        $display("FAIL code_order: got %0d expected %0d", bus.y, e);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b0011;
        bus.ready = 1'b0;
        step(); step();
        check("rst_valid", int'(bus.valid), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_pending", int'(dbg_pending), 0);
        check("rst_state", int'(dbg_state), 0);

        // 1: request held through reset produces no event
        rst       = 1'b0;
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t1_valid", int'(bus.valid), 0);
            check("t1_ovf", int'(bus.ovf), 0);
        end
        req = 4'b0000;
        step(); step();

        // 2: single event, latency
        req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        check("t2_pending", int'(dbg_pending), 4'b0100);
        check("t2_valid_e0", int'(bus.valid), 0);
        step();
        check("t2_valid_e1", int'(bus.valid), 1);
        check("t2_y", int'(bus.y), 2);
        step();
        check("t2_valid_done", int'(bus.valid), 0);
        check("t2_pending_done", int'(dbg_pending), 0);
        req = 4'b0000;
        step();

        // 3: three simultaneous rises, back-to-back delivery
        req = 4'b1011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        step();
        check("t3_v0", int'(bus.valid), 1);
        check("t3_y0", int'(bus.y), 0);
        step();
        check("t3_v1", int'(bus.valid), 1);
        check("t3_y1", int'(bus.y), 1);
        step();
        check("t3_v2", int'(bus.valid), 1);
        check("t3_y2", int'(bus.y), 3);
        step();
        check("t3_valid_done", int'(bus.valid), 0);
        req = 4'b0000;
        step();

        // 4: stall holds offer stable
        bus.ready = 1'b0;
        req = 4'b0110;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_stall_valid", int'(bus.valid), 1);
            check("t4_stall_y", int'(bus.y), 1);
        end
        bus.ready = 1'b1;
        step();
        check("t4_valid_y2", int'(bus.valid), 1);
        check("t4_y2", int'(bus.y), 2);
        step();
        check("t4_valid_done", int'(bus.valid), 0);
        req = 4'b0000;
        step();

        // 5: overflow on a pending, not-offered bit
        ovf_cnt   = 0;
        bus.ready = 1'b0;
        req = 4'b1001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        step();
        step();
        check("t5_offer_y", int'(bus.y), 0);
        req = 4'b0001;
        step();
        req = 4'b1001;
        step();
        check("t5_ovf_pulse", int'(bus.ovf), 1);
        check("t5_pending", int'(dbg_pending), 4'b1001);
        step();
        check("t5_ovf_clear", int'(bus.ovf), 0);
        bus.ready = 1'b1;
        step();
        check("t5_y3", int'(bus.y), 3);
        step();
        check("t5_valid_done", int'(bus.valid), 0);
        step();
        check("t5_valid_stays", int'(bus.valid), 0);
        check("t5_ovf_count", ovf_cnt, 1);
        req = 4'b0000;
        step();

        // 6: same-cycle set and clear on the offered bit
        ovf_cnt   = 0;
        bus.ready = 1'b0;
        req = 4'b0010;
        exp_q.push_back(2'd1);
        step();
        step();
        check("t6_offer_y", int'(bus.y), 1);
        req = 4'b0000;
        step();
        bus.ready = 1'b1;
        req = 4'b0010;
        exp_q.push_back(2'd1);
        step();
        check("t6_idle_valid", int'(bus.valid), 0);
        check("t6_ovf", int'(bus.ovf), 0);
        check("t6_pending", int'(dbg_pending), 4'b0010);
        step();
        check("t6_reoffer_valid", int'(bus.valid), 1);
        check("t6_reoffer_y", int'(bus.y), 1);
        step();
        check("t6_valid_done", int'(bus.valid), 0);
        check("t6_ovf_count", ovf_cnt, 0);
        req = 4'b0000;
        step();

        // reset mid-offer discards everything
        bus.ready = 1'b0;
        req = 4'b0101;
        step();
        step();
        check("rm_offer_valid", int'(bus.valid), 1);
        rst = 1'b1;
        step();
        check("rm_valid", int'(bus.valid), 0);
        check("rm_pending", int'(dbg_pending), 0);
        check("rm_y", int'(bus.y), 0);
        rst = 1'b0;
        bus.ready = 1'b1;
        step(); step(); step();
        check("rm_no_event", int'(bus.valid), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
